// File: rtl/burst_master_port.sv
// Bus master port: arbitrates, shifts header and write beats out on 1-bit lanes, deserialises read beats.
// Header starts the cycle after grant; grant loss aborts with tx_err; MASTER_TIMEOUT_EN adds a stall timeout.
module burst_master_port #(
  parameter int ADDR_LEN       = 12,
  parameter int DATA_LEN       = 8,
  parameter int BURST_LEN      = 12,
  parameter int SLAVE_LEN      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_LEN-1:0]  cmd_addr,
  input  logic [SLAVE_LEN-1:0] cmd_slave,
  input  logic [BURST_LEN-1:0] cmd_burst,
  input  logic [DATA_LEN-1:0]  wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DATA_LEN-1:0]  rd_data,
  output logic                 rd_valid,
  output logic                 approval_request,
  input  logic                 approval_grant,
  input  logic                 busy,
  output logic                 tx_slave_select,
  output logic                 tx_address,
  output logic                 tx_burst_number,
  output logic                 tx_data,
  output logic                 master_valid,
  output logic                 write_en,
  output logic                 read_en,
  input  logic                 slave_ready,
  input  logic                 slave_valid,
  input  logic                 rx_data,
  output logic                 master_ready,
  output logic                 tx_done,
  output logic                 tx_err
);

  localparam int CNT_MAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HDR_LAST = CW'(ADDR_LEN - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(DATA_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_HDR, S_WR_LOAD, S_WR_WAIT, S_WR_SHIFT, S_RD_SHIFT, S_RD_OUT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 write_q, write_d;
  logic [BURST_LEN-1:0] beats_q, beats_d;
  logic [ADDR_LEN-1:0]  hsl_q, hsl_d, had_q, had_d, hbu_q, hbu_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_LEN-1:0]  sr_q, sr_d, rd_q, rd_d;
  logic [TW-1:0]        stall_q, stall_d;
  logic                 on_bus, stalled, timeout_hit;

  assign on_bus = state_q inside {S_HDR, S_WR_LOAD, S_WR_WAIT, S_WR_SHIFT, S_RD_SHIFT, S_RD_OUT};

`ifdef MASTER_TIMEOUT_EN
  assign stalled = ((state_q == S_REQ)      && !(approval_grant && !busy)) ||
                   ((state_q == S_WR_WAIT)  && !slave_ready) ||
                   ((state_q == S_RD_SHIFT) && !slave_valid);
`else
  assign stalled = 1'b0;
`endif
  assign timeout_hit = stalled && (stall_q == TO_LAST);

  assign rd_data = rd_q;
  assign tx_err  = err_q;

  always_comb begin
    state_d          = state_q;
    ready_d          = 1'b1;
    err_d            = 1'b0;
    write_d          = write_q;
    beats_d          = beats_q;
    hsl_d            = hsl_q;
    had_d            = had_q;
    hbu_d            = hbu_q;
    cnt_d            = cnt_q;
    sr_d             = sr_q;
    rd_d             = rd_q;
    stall_d          = stalled ? stall_q + 1'b1 : '0;
    cmd_ready        = 1'b0;
    wr_ready         = 1'b0;
    rd_valid         = 1'b0;
    approval_request = 1'b0;
    tx_slave_select  = 1'b0;
    tx_address       = 1'b0;
    tx_burst_number  = 1'b0;
    tx_data          = 1'b0;
    master_valid     = 1'b0;
    write_en         = 1'b0;
    read_en          = 1'b0;
    master_ready     = 1'b0;
    tx_done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ready_q keeps cmd_ready low until the first clock after reset release
        cmd_ready = ready_q;
        if (ready_q && cmd_valid) begin
          write_d = cmd_write;
          hsl_d   = ADDR_LEN'(cmd_slave);
          had_d   = cmd_addr;
          hbu_d   = ADDR_LEN'(cmd_burst);
          beats_d = (cmd_burst == '0) ? BURST_LEN'(1) : cmd_burst;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        approval_request = !busy;
        if (approval_grant && !busy) begin
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        approval_request = 1'b1;
        master_valid     = 1'b1;
        tx_slave_select  = hsl_q[0];
        tx_address       = had_q[0];
        tx_burst_number  = hbu_q[0];
        hsl_d            = hsl_q >> 1;
        had_d            = had_q >> 1;
        hbu_d            = hbu_q >> 1;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == HDR_LAST) begin
          cnt_d   = '0;
          state_d = write_q ? S_WR_LOAD : S_RD_SHIFT;
        end
      end
      S_WR_LOAD: begin
        approval_request = 1'b1;
        // no word is taken in the cycle the grant is lost
        wr_ready         = approval_grant;
        if (approval_grant && wr_valid) begin
          sr_d    = wr_data;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        approval_request = 1'b1;
        write_en         = 1'b1;
        if (slave_ready) begin
          cnt_d   = '0;
          state_d = S_WR_SHIFT;
        end
      end
      S_WR_SHIFT: begin
        approval_request = 1'b1;
        master_valid     = 1'b1;
        write_en         = 1'b1;
        tx_data          = sr_q[0];
        sr_d             = sr_q >> 1;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == DAT_LAST) begin
          cnt_d   = '0;
          beats_d = beats_q - 1'b1;
          state_d = (beats_q == BURST_LEN'(1)) ? S_DONE : S_WR_LOAD;
        end
      end
      S_RD_SHIFT: begin
        approval_request = 1'b1;
        read_en          = 1'b1;
        master_ready     = 1'b1;
        if (slave_valid) begin
          sr_d  = {rx_data, sr_q[DATA_LEN-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DAT_LAST) begin
            cnt_d   = '0;
            rd_d    = {rx_data, sr_q[DATA_LEN-1:1]};
            state_d = S_RD_OUT;
          end
        end
      end
      S_RD_OUT: begin
        approval_request = 1'b1;
        rd_valid         = 1'b1;
        beats_d          = beats_q - 1'b1;
        state_d          = (beats_q == BURST_LEN'(1)) ? S_DONE : S_RD_SHIFT;
      end
      S_DONE: begin
        tx_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((on_bus && !approval_grant) || timeout_hit) begin
      err_d   = 1'b1;
      stall_d = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      beats_q <= '0;
      hsl_q   <= '0;
      had_q   <= '0;
      hbu_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      write_q <= write_d;
      beats_q <= beats_d;
      hsl_q   <= hsl_d;
      had_q   <= had_d;
      hbu_q   <= hbu_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
    end
  end

endmodule
